// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb_pkg : shared state encoding and id-width helper for rr_stream_arbiter
// Revision   : 1.0
// ---------------------------------------------------------------------------
package rr_arb_pkg;

  typedef enum logic [0:0] {
    RR_IDLE = 1'b0,
    RR_HOLD = 1'b1
  } rr_state_e;

  // A single requester still needs a 1-bit id port.
  function automatic int rr_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb_pick : stateless round-robin pick, first valid at or above i_ptr (wrapping)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = rr_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_grant,
  output logic               o_any
);

  int w_dist;
  int w_best;

  // Distance from the pointer in wrapped order; the smallest distance wins.
  always_comb begin
    o_grant = i_ptr;
    o_any   = 1'b0;
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + NUM_REQ - int'(i_ptr));
      if (i_valid[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = ID_W'(i);
        o_any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_stream_arbiter : zero-latency round-robin stream arbiter with grant hold.
// Option macro RR_ARB_PKT_LOCK_EN keeps the grant until the out_last beat.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module rr_stream_arbiter
  import rr_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 8,
  parameter type TYPE       = logic [DATA_WIDTH-1:0]
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  TYPE                             req_data [NUM_REQ],
  input  logic [NUM_REQ-1:0]              req_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output TYPE                             out_data,
  output logic                            out_last,
  output logic [rr_id_width(NUM_REQ)-1:0] out_id
);

  localparam int c_ID_W = rr_id_width(NUM_REQ);

  rr_state_e         r_state;
  rr_state_e         w_state_nxt;
  logic [c_ID_W-1:0] r_grant;
  logic [c_ID_W-1:0] w_grant_nxt;
  logic [c_ID_W-1:0] r_ptr;
  logic [c_ID_W-1:0] w_ptr_nxt;
  logic [c_ID_W-1:0] w_pick_grant;
  logic              w_pick_any;
  logic [c_ID_W-1:0] w_grant;
  logic              w_hs;
  logic              w_end;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (c_ID_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_any   (w_pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RR_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_grant   = (r_state == RR_HOLD) ? r_grant : w_pick_grant;
    out_valid = 1'b0;
    out_data  = req_data[0];
    out_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == c_ID_W'(i)) begin
        out_valid    = req_valid[i];
        out_data     = req_data[i];
        out_last     = req_last[i];
        req_ready[i] = out_ready;
      end
    end
    if (r_state == RR_IDLE) begin
      out_valid = w_pick_any;
    end
    // Handshakes are suppressed outright while reset is held.
    if (!rstn) begin
      out_valid = 1'b0;
      req_ready = '0;
    end
    out_id = w_grant;

    w_hs = out_valid & out_ready;
`ifdef RR_ARB_PKT_LOCK_EN
    w_end = out_last;
`else
    w_end = 1'b1;
`endif

    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    if (w_hs && w_end) begin
      w_state_nxt = RR_IDLE;
      w_ptr_nxt   = (w_grant == c_ID_W'(NUM_REQ - 1)) ? '0 : (w_grant + c_ID_W'(1));
    end else if (out_valid) begin
      w_state_nxt = RR_HOLD;
      w_grant_nxt = w_grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_stream_arbiter : directed vectors for rr_stream_arbiter (4- and 3-way)
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_rr_stream_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] req_last;
  logic [7:0] req_data [4];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_id;

  logic [2:0] v3_valid;
  logic [2:0] v3_ready;
  logic [2:0] v3_last;
  logic [7:0] v3_data [3];
  logic       v3_out_valid;
  logic       v3_out_ready;
  logic [7:0] v3_out_data;
  logic       v3_out_last;
  logic [1:0] v3_out_id;

  rr_stream_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  rr_stream_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) u_dut3 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (v3_valid),
    .req_ready (v3_ready),
    .req_data  (v3_data),
    .req_last  (v3_last),
    .out_valid (v3_out_valid),
    .out_ready (v3_out_ready),
    .out_data  (v3_out_data),
    .out_last  (v3_out_last),
    .out_id    (v3_out_id)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic       exp_valid;
    logic [1:0] exp_id;
    logic [7:0] exp_data;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t       vecs [13];
  logic [1:0] exp_ids [4];
  int         beats;

  initial begin
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    req_data[2] = 8'h5A;
    req_data[3] = 8'h77;
    v3_data[0]  = 8'hC0;
    v3_data[1]  = 8'hC1;
    v3_data[2]  = 8'hC2;
    req_valid    = 4'b1111;
    req_last     = 4'b1111;
    out_ready    = 1'b1;
    v3_valid     = 3'b000;
    v3_last      = 3'b111;
    v3_out_ready = 1'b0;

    // ptr carried between rows: 0,1,2,3,0 rotation, idle, then a 3-cycle stall on req2
    vecs[0]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0001};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 8'h22, 4'b0010};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 8'h5A, 4'b0100};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 8'h77, 4'b1000};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0001};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000};
    vecs[6]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 8'h22, 4'b0010};
    vecs[7]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 8'h5A, 4'b0000};
    vecs[8]  = '{4'b0101, 1'b0, 1'b1, 2'd2, 8'h5A, 4'b0000};
    vecs[9]  = '{4'b0101, 1'b0, 1'b1, 2'd2, 8'h5A, 4'b0000};
    vecs[10] = '{4'b0101, 1'b1, 1'b1, 2'd2, 8'h5A, 4'b0100};
    vecs[11] = '{4'b0001, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0001};
    vecs[12] = '{4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000};

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int k = 0; k < 13; k++) begin
      req_valid = vecs[k].valid;
      out_ready = vecs[k].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        chk($sformatf("vec%0d_id", k), 32'(out_id), 32'(vecs[k].exp_id));
        chk($sformatf("vec%0d_data", k), 32'(out_data), 32'(vecs[k].exp_data));
        chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
        chk($sformatf("vec%0d_last", k), 32'(out_last), 32'd1);
      end
      @(posedge clk); #1;
    end

    // req1 sends a 3-beat packet while req3 keeps offering single beats; ptr=1
`ifdef RR_ARB_PKT_LOCK_EN
    exp_ids = '{2'd1, 2'd1, 2'd1, 2'd3};
`else
    exp_ids = '{2'd1, 2'd3, 2'd1, 2'd3};
`endif
    beats = 3;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = {1'b1, 1'b0, (beats > 0), 1'b0};
      req_last  = {1'b1, 1'b0, (beats == 1), 1'b0};
      @(negedge clk);
      chk($sformatf("pkt%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("pkt%0d_id", k), 32'(out_id), 32'(exp_ids[k]));
      chk($sformatf("pkt%0d_last", k), 32'(out_last),
          (exp_ids[k] == 2'd1) ? 32'(beats == 1) : 32'd1);
      @(posedge clk); #1;
      if (exp_ids[k] == 2'd1) beats--;
    end
    req_last = 4'b1111;

    // Move ptr off zero, then park a HOLD on req2 and hit it with reset
    req_valid = 4'b0001;
    @(negedge clk);
    chk("pre_rst_id0", 32'(out_id), 32'd0);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_id2", 32'(out_id), 32'd2);
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_id", 32'(out_id), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0000;

    // Three requesters: reach ptr=2, then wrap to req0
    v3_out_ready = 1'b1;
    v3_valid = 3'b010;
    @(negedge clk);
    chk("n3_first_id", 32'(v3_out_id), 32'd1);
    @(posedge clk); #1;
    v3_valid = 3'b001;
    @(negedge clk);
    chk("n3_wrap_valid", 32'(v3_out_valid), 32'd1);
    chk("n3_wrap_id", 32'(v3_out_id), 32'd0);
    chk("n3_wrap_ready", 32'(v3_ready), 32'd1);
    chk("n3_wrap_data", 32'(v3_out_data), 32'hC0);
    @(posedge clk); #1;
    v3_valid = 3'b111;
    @(negedge clk);
    chk("n3_ptr_after_wrap", 32'(v3_out_id), 32'd1);
    @(posedge clk); #1;
    v3_valid = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, any value 1..16, not limited to powers of two.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload width.
REQ-003 SHALL have parameter type TYPE, default logic [DATA_WIDTH-1:0]: payload type.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, [NUM_REQ]: per-requester valid.
REQ-007 SHALL have port req_ready, output, [NUM_REQ]: per-requester ready.
REQ-008 SHALL have port req_data, input, TYPE [NUM_REQ]: per-requester payload.
REQ-009 SHALL have port req_last, input, [NUM_REQ]: last beat of a packet.
REQ-010 SHALL have port out_valid, output, 1 bit: output valid; connects to a FIFO's w_valid.
REQ-011 SHALL have port out_ready, input, 1 bit: output ready; driven from FIFO w_ready.
REQ-012 SHALL have port out_data, output, TYPE: granted payload.
REQ-013 SHALL have port out_last, output, 1 bit: granted req_last.
REQ-014 SHALL have port out_id, output, max(1,$clog2(NUM_REQ)) bits: index of the granted requester.

Function
REQ-015 SHALL implement two states: IDLE (no grant held) and HOLD (grant register valid).
REQ-016 In IDLE, the grant SHALL be the first requester with req_valid=1, searching from priority pointer ptr upward and wrapping from NUM_REQ-1 to 0.
REQ-017 The grant SHALL be visible in the same cycle: zero latency, with out_valid = req_valid[grant] combinationally.
REQ-018 req_ready[i] SHALL equal out_ready when i is granted, else 0.
REQ-019 out_data, out_last and out_id SHALL reflect the granted requester; they are don't-care when out_valid=0.
REQ-020 If out_valid=1 and out_ready=0, the state SHALL go to HOLD and keep the current grant, so out_data and out_id stay stable until handshake.
REQ-021 In HOLD, no re-arbitration SHALL occur, even if a higher-priority requester asserts valid.
REQ-022 On a handshake that ends the grant, ptr SHALL be set to (grant+1) mod NUM_REQ, and the state SHALL go to IDLE.
REQ-023 After REQ-022, re-arbitration SHALL take effect in the next cycle; there are no back-to-back grants within one cycle.
REQ-024 The grant SHALL end on a handshake per REQ-031/REQ-032.
REQ-025 A handshake that does not end the grant SHALL leave the state in HOLD with the same grant.
REQ-026 With no requester valid in IDLE: out_valid=0, and ptr is unchanged.
REQ-027 With NUM_REQ=1: grant is always 0, out_id=0, and the block is a pass-through apart from the state.

Reset
REQ-028 On rstn low, the state SHALL be IDLE and ptr SHALL be 0.
REQ-029 While rstn is low, out_valid SHALL be 0 and all req_ready SHALL be 0.
REQ-030 A packet or hold in progress when reset is asserted SHALL be abandoned; there is no residual grant after release.

Configuration
REQ-031 With macro RR_ARB_PKT_LOCK_EN defined: the grant SHALL persist from the first accepted beat until a handshake with out_last=1; packets from different requesters never interleave.
REQ-032 Without RR_ARB_PKT_LOCK_EN: every handshake SHALL end the grant, giving per-beat round-robin; req_last passes through to out_last without affecting arbitration.

Structure
REQ-033 Package rr_arb_pkg SHALL hold the state enum typedef (RR_IDLE, RR_HOLD) and a localparam function for id width.
REQ-034 Sub-module rr_arb_pick SHALL contain the combinational logic that maps (valid vector, ptr) to (grant index, any-valid); it contains no state.
REQ-035 The top SHALL contain the state register, grant register, ptr register and output muxing.

Verification
REQ-036 NUM_REQ=4, all valid, out_ready=1, no lock, single beats: grants SHALL follow 0,1,2,3,0 in consecutive handshakes.
REQ-037 Req2 valid with data 0x5A, out_ready=0 for 3 cycles, then req0 valid in cycle 2: out_id SHALL stay 2 and out_data 0x5A until out_ready=1; req0 SHALL be granted next.
REQ-038 Lock enabled, req1 sends a 3-beat packet while req3 is valid: out_id SHALL be 1 for all 3 beats, then 3.
REQ-039 Lock disabled, same stimulus as REQ-038: beats SHALL alternate 1,3,1,3.
REQ-040 Reset pulsed during HOLD on req2: out_valid SHALL be 0 during reset; after release with all valid, the first grant SHALL be 0.
REQ-041 NUM_REQ=3, ptr=2, only req0 valid: grant SHALL be 0 via wrap-around; ptr SHALL be 1 after the handshake.
